// File: rtl/dla_axi_lite_regs_if.sv
// AXI-Lite bus bundle (AW, W, B, AR and R channels) used between the DLA manager and its register bank.
// Latency: none. This file only groups wires.
// Backpressure: standard valid/ready on every channel. The Master modport drives the valids and b_ready/r_ready.
interface AXI_LITE #(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]                  aw_prot;
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_valid;
  logic                        w_ready;
  logic [1:0]                  b_resp;
  logic                        b_valid;
  logic                        b_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]                  ar_prot;
  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport Slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/dla_axi_lite_regs.sv
// AXI-Lite subordinate register bank: N_REGS RW control registers followed by N_STATUS RO status words.
// Latency: write commits and b_valid rises 1 cycle after the later AW/W handshake; r_valid rises on the AR handshake edge.
// Backpressure: b_valid/r_valid are held until b_ready/r_ready, and each channel stalls independently of the other.
// Ports: clk_i/rstn_i (async active-low reset), pp_if (AXI-Lite slave), ctrl_regs_o (reg k at [k*W +: W]),
//        wr_pulse_o (1-cycle pulse per written reg), status_i (status word s at [s*W +: W]).
module dla_axi_lite_regs #(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int N_REGS         = 8,
  parameter int N_STATUS       = 4
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  AXI_LITE.Slave                             pp_if,
  output logic [N_REGS*AXI_DATA_WIDTH-1:0]   ctrl_regs_o,
  output logic [N_REGS-1:0]                  wr_pulse_o,
  input  logic [N_STATUS*AXI_DATA_WIDTH-1:0] status_i
);
  localparam int W      = AXI_DATA_WIDTH;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = AXI_ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {TGT_RW, TGT_RO, TGT_NONE} tgt_e;
  typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_B} wr_state_e;
  typedef enum logic       {RD_IDLE, RD_DATA} rd_state_e;

  function automatic tgt_e decode(input logic [IDX_W-1:0] idx);
    if (idx < IDX_W'(N_REGS))                 return TGT_RW;
    else if (idx < IDX_W'(N_REGS + N_STATUS)) return TGT_RO;
    else                                      return TGT_NONE;
  endfunction

  // Write channel state
  wr_state_e               wr_state;
  logic                    aw_ready_q, w_ready_q;
  logic                    aw_got_q, w_got_q;
  logic                    b_valid_q;
  logic [1:0]              b_resp_q;
  logic [IDX_W-1:0]        aw_idx_q;
  logic [W-1:0]            w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic [N_REGS-1:0][W-1:0] ctrl_q;
  logic [N_REGS-1:0]       wr_pulse_q;

  // Read channel state
  rd_state_e               rd_state;
  logic                    ar_ready_q;
  logic                    r_valid_q;
  logic [1:0]              r_resp_q;
  logic [W-1:0]            r_data_q;

  logic                    aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]        ar_idx;
  logic [W-1:0]            rw_rdata, ro_rdata;
  logic                    unused_bits;

  assign aw_hs  = pp_if.aw_valid && aw_ready_q;
  assign w_hs   = pp_if.w_valid && w_ready_q;
  assign ar_hs  = pp_if.ar_valid && ar_ready_q;
  assign ar_idx = pp_if.ar_addr[AXI_ADDR_WIDTH-1:2];

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_bits = ^{pp_if.aw_prot, pp_if.ar_prot, pp_if.aw_addr[1:0], pp_if.ar_addr[1:0]};

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_state   <= WR_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      ctrl_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      case (wr_state)
        WR_IDLE: begin
          // Each channel is captured once; its ready stays low until the response completes.
          // A ready that is low without a capture (first cycle after reset) is raised here.
          if (aw_hs) begin
            aw_idx_q   <= pp_if.aw_addr[AXI_ADDR_WIDTH-1:2];
            aw_got_q   <= 1'b1;
            aw_ready_q <= 1'b0;
          end else if (!aw_got_q) begin
            aw_ready_q <= 1'b1;
          end
          if (w_hs) begin
            w_data_q  <= pp_if.w_data;
            w_strb_q  <= pp_if.w_strb;
            w_got_q   <= 1'b1;
            w_ready_q <= 1'b0;
          end else if (!w_got_q) begin
            w_ready_q <= 1'b1;
          end
          if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
            wr_state <= WR_COMMIT;
          end
        end
        WR_COMMIT: begin
          aw_got_q <= 1'b0;
          w_got_q  <= 1'b0;
          if (decode(aw_idx_q) == TGT_RW) begin
            b_resp_q <= RESP_OKAY;
            for (int k = 0; k < N_REGS; k++) begin
              if (aw_idx_q == IDX_W'(k)) begin
                for (int i = 0; i < STRB_W; i++) begin
                  if (w_strb_q[i]) begin
                    ctrl_q[k][i*8 +: 8] <= w_data_q[i*8 +: 8];
                  end
                end
                // An all-zero strobe changes nothing, so nothing is announced.
                wr_pulse_q[k] <= |w_strb_q;
              end
            end
          end else begin
            b_resp_q <= RESP_SLVERR;
          end
          b_valid_q <= 1'b1;
          wr_state  <= WR_B;
        end
        WR_B: begin
          if (pp_if.b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            wr_state   <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- read decode
  always_comb begin
    rw_rdata = '0;
    ro_rdata = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (ar_idx == IDX_W'(k)) rw_rdata = ctrl_q[k];
    end
    for (int s = 0; s < N_STATUS; s++) begin
      if (ar_idx == IDX_W'(N_REGS + s)) ro_rdata = status_i[s*W +: W];
    end
  end

  // ---------------------------------------------------------------- read FSM
  // ctrl_q is sampled before any same-edge commit lands, so a colliding read sees the old value.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_state   <= RD_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b1;
            rd_state   <= RD_DATA;
            case (decode(ar_idx))
              TGT_RW: begin
                r_data_q <= rw_rdata;
                r_resp_q <= RESP_OKAY;
              end
              TGT_RO: begin
                r_data_q <= ro_rdata;
                r_resp_q <= RESP_OKAY;
              end
              default: begin
                r_data_q <= '0;
                r_resp_q <= RESP_SLVERR;
              end
            endcase
          end else begin
            ar_ready_q <= 1'b1;
          end
        end
        RD_DATA: begin
          if (pp_if.r_ready) begin
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
            rd_state   <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign pp_if.aw_ready = aw_ready_q;
  assign pp_if.w_ready  = w_ready_q;
  assign pp_if.b_valid  = b_valid_q;
  assign pp_if.b_resp   = b_resp_q;
  assign pp_if.ar_ready = ar_ready_q;
  assign pp_if.r_valid  = r_valid_q;
  assign pp_if.r_resp   = r_resp_q;
  assign pp_if.r_data   = r_data_q;
  assign ctrl_regs_o    = ctrl_q;
  assign wr_pulse_o     = wr_pulse_q;
endmodule

// File: tb/tb_dla_axi_lite_regs.sv
module tb_dla_axi_lite_regs;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic clk = 1'b0;
  logic rstn_i;
  logic [255:0] ctrl_regs_o;
  logic [7:0]   wr_pulse_o;
  logic [127:0] status_i;

  AXI_LITE #(.AXI_ADDR_WIDTH(16), .AXI_DATA_WIDTH(32)) pp_if ();

  dla_axi_lite_regs #(
    .AXI_ADDR_WIDTH(16), .AXI_DATA_WIDTH(32), .N_REGS(8), .N_STATUS(4)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i), .pp_if(pp_if),
    .ctrl_regs_o(ctrl_regs_o), .wr_pulse_o(wr_pulse_o), .status_i(status_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0][31:0] model;

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          awd;    // cycles before aw_valid is raised
    int          wd;     // cycles before w_valid is raised
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic        upd;
    int          ridx;
    logic [31:0] rval;   // new register value (write) or expected r_data (read)
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs AW and W until both are accepted, then steps through the commit cycle.
  // Returns one cycle after the commit edge, where b_valid is expected high.
  task automatic write_phase(input string nm, input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int awd, input int wd);
    logic aw_got, w_got, aw_hs, w_hs;
    aw_got = 1'b0;
    w_got  = 1'b0;
    pp_if.aw_addr = addr;
    pp_if.w_data  = data;
    pp_if.w_strb  = strb;
    for (int c = 0; c < 20 && !(aw_got && w_got); c++) begin
      if (!aw_got && c >= awd) pp_if.aw_valid = 1'b1;
      if (!w_got && c >= wd)   pp_if.w_valid  = 1'b1;
      aw_hs = pp_if.aw_valid && pp_if.aw_ready;
      w_hs  = pp_if.w_valid && pp_if.w_ready;
      tick();
      if (aw_hs) begin aw_got = 1'b1; pp_if.aw_valid = 1'b0; end
      if (w_hs)  begin w_got  = 1'b1; pp_if.w_valid  = 1'b0; end
    end
    pp_if.aw_valid = 1'b0;
    pp_if.w_valid  = 1'b0;
    check($sformatf("%s aw/w accepted", nm), {aw_got, w_got}, 2'b11);
    check($sformatf("%s b_valid in commit", nm), pp_if.b_valid, 1'b0);
    check($sformatf("%s w_ready low after capture", nm), pp_if.w_ready, 1'b0);
    tick();
  endtask

  task automatic b_finish(input string nm);
    pp_if.b_ready = 1'b1;
    tick();
    pp_if.b_ready = 1'b0;
    check($sformatf("%s b_valid after hs", nm), pp_if.b_valid, 1'b0);
    check($sformatf("%s aw/w_ready after hs", nm), {pp_if.aw_ready, pp_if.w_ready}, 2'b11);
    check($sformatf("%s pulse cleared", nm), wr_pulse_o, 8'h00);
  endtask

  // Returns one cycle after the AR handshake edge, where r_valid is expected high.
  task automatic read_phase(input string nm, input logic [15:0] addr);
    logic got, hs;
    got = 1'b0;
    pp_if.ar_addr  = addr;
    pp_if.ar_valid = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      hs = pp_if.ar_valid && pp_if.ar_ready;
      tick();
      if (hs) got = 1'b1;
    end
    pp_if.ar_valid = 1'b0;
    check($sformatf("%s ar accepted", nm), got, 1'b1);
    check($sformatf("%s r_valid", nm), pp_if.r_valid, 1'b1);
    check($sformatf("%s ar_ready low", nm), pp_if.ar_ready, 1'b0);
  endtask

  task automatic r_finish(input string nm);
    pp_if.r_ready = 1'b1;
    tick();
    pp_if.r_ready = 1'b0;
    check($sformatf("%s r_valid after hs", nm), pp_if.r_valid, 1'b0);
    check($sformatf("%s ar_ready after hs", nm), pp_if.ar_ready, 1'b1);
  endtask

  task automatic check_all_reset(input string nm);
    check($sformatf("%s readies", nm), {pp_if.aw_ready, pp_if.w_ready, pp_if.ar_ready}, 3'b000);
    check($sformatf("%s valids", nm), {pp_if.b_valid, pp_if.r_valid}, 2'b00);
    check($sformatf("%s resps", nm), {pp_if.b_resp, pp_if.r_resp}, 4'h0);
    check($sformatf("%s r_data", nm), pp_if.r_data, 32'h0);
    check($sformatf("%s ctrl_regs", nm), ctrl_regs_o, 256'h0);
    check($sformatf("%s wr_pulse", nm), wr_pulse_o, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //        wr    addr      data          strb awd wd resp pulse  upd ridx rval
    vecs[0]  = '{1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 1, OK,  8'h02, 1'b1, 1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 0, 0, OK,  8'h00, 1'b0, 0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 16'h0008, 32'h11223344, 4'hF, 0, 0, OK,  8'h04, 1'b1, 2, 32'h11223344};
    vecs[3]  = '{1'b1, 16'h0008, 32'hAABBCCDD, 4'h5, 1, 0, OK,  8'h04, 1'b1, 2, 32'h11BB33DD};
    vecs[4]  = '{1'b0, 16'h0008, 32'h0,        4'h0, 0, 0, OK,  8'h00, 1'b0, 0, 32'h11BB33DD};
    vecs[5]  = '{1'b0, 16'h0020, 32'h0,        4'h0, 0, 0, OK,  8'h00, 1'b0, 0, 32'h0000CAFE};
    vecs[6]  = '{1'b0, 16'h0024, 32'h0,        4'h0, 0, 0, OK,  8'h00, 1'b0, 0, 32'h12345678};
    vecs[7]  = '{1'b0, 16'h002C, 32'h0,        4'h0, 0, 0, OK,  8'h00, 1'b0, 0, 32'h9ABCDEF0};
    vecs[8]  = '{1'b1, 16'h0020, 32'h55555555, 4'hF, 0, 0, ERR, 8'h00, 1'b0, 0, 32'h0};
    vecs[9]  = '{1'b0, 16'h0040, 32'h0,        4'h0, 0, 0, ERR, 8'h00, 1'b0, 0, 32'h0};
    vecs[10] = '{1'b0, 16'h0030, 32'h0,        4'h0, 0, 0, ERR, 8'h00, 1'b0, 0, 32'h0};
    vecs[11] = '{1'b1, 16'h0040, 32'h66666666, 4'hF, 0, 2, ERR, 8'h00, 1'b0, 0, 32'h0};
    vecs[12] = '{1'b1, 16'h001C, 32'hCAFEF00D, 4'hF, 2, 0, OK,  8'h80, 1'b1, 7, 32'hCAFEF00D};
    vecs[13] = '{1'b1, 16'h001E, 32'h01020304, 4'h2, 0, 0, OK,  8'h80, 1'b1, 7, 32'hCAFE030D};
    vecs[14] = '{1'b1, 16'h000C, 32'hFFFFFFFF, 4'h0, 0, 0, OK,  8'h00, 1'b0, 0, 32'h0};
    vecs[15] = '{1'b0, 16'h001C, 32'h0,        4'h0, 0, 0, OK,  8'h00, 1'b0, 0, 32'hCAFE030D};
    vecs[16] = '{1'b0, 16'h0000, 32'h0,        4'h0, 0, 0, OK,  8'h00, 1'b0, 0, 32'h00000000};

    model    = '0;
    status_i = {32'h9ABCDEF0, 32'h0BADF00D, 32'h12345678, 32'h0000CAFE};
    rstn_i   = 1'b0;
    pp_if.aw_addr = '0; pp_if.aw_prot = '0; pp_if.aw_valid = 1'b0;
    pp_if.w_data  = '0; pp_if.w_strb  = '0; pp_if.w_valid  = 1'b0;
    pp_if.b_ready = 1'b0;
    pp_if.ar_addr = '0; pp_if.ar_prot = '0; pp_if.ar_valid = 1'b0;
    pp_if.r_ready = 1'b0;

    repeat (3) tick();
    check_all_reset("reset");
    rstn_i = 1'b1;
    check("ready before first edge", {pp_if.aw_ready, pp_if.w_ready, pp_if.ar_ready}, 3'b000);
    tick();
    check("ready after first edge", {pp_if.aw_ready, pp_if.w_ready, pp_if.ar_ready}, 3'b111);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        write_phase($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb,
                    vecs[i].awd, vecs[i].wd);
        if (vecs[i].upd) model[vecs[i].ridx] = vecs[i].rval;
        check($sformatf("vec%0d b_valid", i), pp_if.b_valid, 1'b1);
        check($sformatf("vec%0d b_resp", i), pp_if.b_resp, vecs[i].resp);
        check($sformatf("vec%0d wr_pulse", i), wr_pulse_o, vecs[i].pulse);
        check($sformatf("vec%0d ctrl_regs", i), ctrl_regs_o, model);
        b_finish($sformatf("vec%0d", i));
      end else begin
        read_phase($sformatf("vec%0d", i), vecs[i].addr);
        check($sformatf("vec%0d r_data", i), pp_if.r_data, vecs[i].rval);
        check($sformatf("vec%0d r_resp", i), pp_if.r_resp, vecs[i].resp);
        r_finish($sformatf("vec%0d", i));
      end
    end

    // Stall: B held for 5 cycles; a read runs and stalls too while B waits.
    write_phase("stall wr", 16'h000C, 32'h55AA55AA, 4'hF, 0, 0);
    model[3] = 32'h55AA55AA;
    check("stall wr ctrl", ctrl_regs_o, model);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("stall b cyc%0d", c), {pp_if.b_valid, pp_if.b_resp, pp_if.aw_ready, pp_if.w_ready},
            {1'b1, OK, 1'b0, 1'b0});
    end
    read_phase("stall rd", 16'h0020);
    status_i[31:0] = 32'hFFFF0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("stall r cyc%0d", c), {pp_if.r_valid, pp_if.r_resp, pp_if.ar_ready, pp_if.r_data},
            {1'b1, OK, 1'b0, 32'h0000CAFE});
      check($sformatf("stall b during r cyc%0d", c), pp_if.b_valid, 1'b1);
    end
    r_finish("stall rd");
    check("b still pending after r", pp_if.b_valid, 1'b1);
    b_finish("stall wr");
    status_i[31:0] = 32'h0000CAFE;

    // Read handshake on the same edge as a commit to the same register returns the old value.
    write_phase("pre coll", 16'h0010, 32'h01010101, 4'hF, 0, 0);
    model[4] = 32'h01010101;
    b_finish("pre coll");
    pp_if.aw_addr = 16'h0010; pp_if.w_data = 32'h02020202; pp_if.w_strb = 4'hF;
    pp_if.aw_valid = 1'b1; pp_if.w_valid = 1'b1;
    tick();
    pp_if.aw_valid = 1'b0; pp_if.w_valid = 1'b0;
    pp_if.ar_addr = 16'h0010; pp_if.ar_valid = 1'b1;
    check("coll ar_ready", pp_if.ar_ready, 1'b1);
    tick();
    pp_if.ar_valid = 1'b0;
    model[4] = 32'h02020202;
    check("coll r_valid", pp_if.r_valid, 1'b1);
    check("coll r_data old", pp_if.r_data, 32'h01010101);
    check("coll b_valid", pp_if.b_valid, 1'b1);
    check("coll ctrl new", ctrl_regs_o, model);
    check("coll pulse", wr_pulse_o, 8'h10);
    r_finish("coll");
    b_finish("coll");

    // Reset while both channels are waiting for their response handshakes.
    write_phase("rst wr", 16'h0014, 32'h00000077, 4'hF, 0, 0);
    read_phase("rst rd", 16'h0014);
    check("rst rd data", pp_if.r_data, 32'h00000077);
    #2;
    rstn_i = 1'b0;
    #1;
    check_all_reset("mid reset");
    model = '0;
    tick();
    rstn_i = 1'b1;
    check("post rst no b", pp_if.b_valid, 1'b0);
    tick();
    check("post rst readies", {pp_if.aw_ready, pp_if.w_ready, pp_if.ar_ready}, 3'b111);
    check("post rst valids", {pp_if.b_valid, pp_if.r_valid}, 2'b00);
    write_phase("fresh wr", 16'h0000, 32'h12345678, 4'hF, 0, 0);
    model[0] = 32'h12345678;
    check("fresh b_resp", {pp_if.b_valid, pp_if.b_resp}, {1'b1, OK});
    check("fresh pulse", wr_pulse_o, 8'h01);
    check("fresh ctrl", ctrl_regs_o, model);
    b_finish("fresh wr");
    read_phase("fresh rd", 16'h0000);
    check("fresh r_data", {pp_if.r_data, pp_if.r_resp}, {32'h12345678, OK});
    r_finish("fresh rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
